// File: rtl/bet_round_controller_if.sv
// Bus bundle between the roulette round controller and its neighbours:
// keyboard bet path, colour sensor, wheel, and the payout evaluator.
// The controller connects through the master modport; whatever drives the
// keyboard/wheel/evaluator side connects through slave.
interface bet_round_controller_if;

  // Keyboard / colour sensor side
  logic        key_strobe;
  logic [5:0]  bet_opcode;
  logic [2:0]  chip_color;

  // Wheel side
  logic        wheel_done;
  logic [5:0]  wheel_number;

  // Payout evaluator side
  logic        eval_ready;

  // Controller outputs
  logic [95:0] bets_packed;
  logic [3:0]  bet_count;
  logic        buf_full;
  logic        spin_req;
  logic        spin_active;
  logic        eval_valid;
  logic [7:0]  eval_bet;
  logic [5:0]  eval_number;
  logic        eval_last;
  logic        round_done;
  logic        timeout_err;
  logic [1:0]  state;

  modport master (
    input  key_strobe, bet_opcode, chip_color,
    input  wheel_done, wheel_number,
    input  eval_ready,
    output bets_packed, bet_count, buf_full,
    output spin_req, spin_active,
    output eval_valid, eval_bet, eval_number, eval_last,
    output round_done, timeout_err, state
  );

  modport slave (
    output key_strobe, bet_opcode, chip_color,
    output wheel_done, wheel_number,
    output eval_ready,
    input  bets_packed, bet_count, buf_full,
    input  spin_req, spin_active,
    input  eval_valid, eval_bet, eval_number, eval_last,
    input  round_done, timeout_err, state
  );

endinterface

// File: rtl/bet_round_controller.sv
// Roulette round sequencer. Collects colour-tagged keyboard bets into a
// 12-slot buffer, requests a wheel spin, waits for the result under a
// timeout, then streams every stored bet together with the winning number
// to the payout evaluator over a valid/ready handshake.
module bet_round_controller #(
  // Cycles spent in SPIN without wheel_done before the spin is abandoned.
  // Must be at least 2 so the spin request cycle is distinct from timeout.
  parameter int unsigned SPIN_TIMEOUT = 500_000_000
) (
  input logic                  clock,
  input logic                  reset,
  bet_round_controller_if.master bus
);

  localparam int          MAX_BETS     = 12;
  localparam logic [5:0]  OP_SPIN      = 6'b111110;
  localparam logic [5:0]  OP_NOP       = 6'b111111;
  localparam logic [3:0]  COUNT_FULL   = 4'(MAX_BETS);
  localparam logic [31:0] TIMEOUT_LAST = 32'(SPIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    BETTING = 2'd0,
    SPIN    = 2'd1,
    EVAL    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;

  logic [7:0]  slot_q [MAX_BETS];
  logic [3:0]  bet_count_q;
  logic [3:0]  index_q;
  logic [31:0] timer_q;
  logic [5:0]  eval_number_q;
  logic        timeout_err_q;

  // One-cycle control strobes from the FSM to the datapath registers
  logic        store_bet;
  logic        start_spin;
  logic        latch_win;
  logic        advance;
  logic        finish_round;
  logic        spin_timeout;

  logic        buf_full;
  logic        is_last;

  assign buf_full = (bet_count_q == COUNT_FULL);
  // bet_count is never 0 while in EVAL, so the subtraction cannot wrap there.
  assign is_last  = (index_q == (bet_count_q - 4'd1));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= BETTING;
    else       state_q <= state_d;
  end

  // Next-state decode and control strobes
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d      = state_q;
    store_bet    = 1'b0;
    start_spin   = 1'b0;
    latch_win    = 1'b0;
    advance      = 1'b0;
    finish_round = 1'b0;
    spin_timeout = 1'b0;

    unique case (state_q)
      BETTING: begin
        if (bus.key_strobe) begin
          if (bus.bet_opcode == OP_SPIN) begin
            // A spin with an empty buffer would settle nothing; drop it.
            if (bet_count_q != 4'd0) begin
              start_spin = 1'b1;
              state_d    = SPIN;
            end
          end else if (bus.bet_opcode != OP_NOP &&
                       bus.chip_color != 3'b000 && !buf_full) begin
            store_bet = 1'b1;
          end
        end
      end

      SPIN: begin
        // A result arriving on the timeout cycle still counts.
        if (bus.wheel_done) begin
          latch_win = 1'b1;
          state_d   = EVAL;
        end else if (timer_q == TIMEOUT_LAST) begin
          spin_timeout = 1'b1;
          state_d      = BETTING;
        end
      end

      EVAL: begin
        if (bus.eval_ready) begin
          if (is_last) begin
            finish_round = 1'b1;
            state_d      = DONE;
          end else begin
            advance = 1'b1;
          end
        end
      end

      DONE: state_d = BETTING;

      default: state_d = BETTING;
    endcase
  end

  // Bet buffer, counters, latched winning number and timeout flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the bet slots are reset explicitly because bets_packed exposes
      // them directly and must read as zero after reset.
      for (int i = 0; i < MAX_BETS; i++) slot_q[i] <= '0;
      bet_count_q   <= '0;
      index_q       <= '0;
      timer_q       <= '0;
      eval_number_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (store_bet) begin
        slot_q[bet_count_q] <= {bus.chip_color[1:0], bus.bet_opcode};
        bet_count_q         <= bet_count_q + 4'd1;
      end

      // The counter restarts on entry so the first SPIN cycle reads zero.
      if (start_spin) begin
        timer_q       <= '0;
        timeout_err_q <= 1'b0;
      end else if (state_q == SPIN) begin
        timer_q <= timer_q + 32'd1;
      end

      // Bets are kept on timeout so the player can simply spin again.
      if (spin_timeout) timeout_err_q <= 1'b1;

      if (latch_win) begin
        eval_number_q <= bus.wheel_number;
        index_q       <= '0;
      end

      if (advance) index_q <= index_q + 4'd1;

      if (finish_round) begin
        for (int i = 0; i < MAX_BETS; i++) slot_q[i] <= '0;
        bet_count_q <= '0;
        index_q     <= '0;
      end
    end
  end

  // Output drive: flatten the buffer and decode state-qualified strobes
  always_comb begin
    bus.bets_packed = '0;
    for (int i = 0; i < MAX_BETS; i++) bus.bets_packed[8*i +: 8] = slot_q[i];

    bus.bet_count   = bet_count_q;
    bus.buf_full    = buf_full;
    bus.state       = state_q;
    bus.spin_active = (state_q == SPIN);
    bus.spin_req    = (state_q == SPIN) && (timer_q == 32'd0);
    bus.eval_valid  = (state_q == EVAL);
    bus.eval_bet    = (state_q == EVAL) ? slot_q[index_q] : 8'h00;
    bus.eval_last   = (state_q == EVAL) && is_last;
    bus.eval_number = eval_number_q;
    bus.round_done  = (state_q == DONE);
    bus.timeout_err = timeout_err_q;
  end

endmodule

// File: tb/tb_bet_round_controller.sv
// Directed bench for bet_round_controller with a short spin timeout (8).
module tb_bet_round_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  bet_round_controller_if bus ();

  bet_round_controller #(.SPIN_TIMEOUT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [5:0] op, input logic [2:0] col);
    bus.key_strobe = 1'b1;
    bus.bet_opcode = op;
    bus.chip_color = col;
    tick();
    bus.key_strobe = 1'b0;
    bus.bet_opcode = 6'h3f;
    bus.chip_color = 3'b000;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [95:0] exp_packed;
    logic [2:0]  col;

    bus.key_strobe   = 1'b0;
    bus.bet_opcode   = 6'h3f;
    bus.chip_color   = 3'b000;
    bus.wheel_done   = 1'b0;
    bus.wheel_number = 6'd0;
    bus.eval_ready   = 1'b0;

    // ---- reset state
    tick();
    tick();
    check("rst_state",      bus.state,       0);
    check("rst_count",      bus.bet_count,   0);
    check("rst_packed",     bus.bets_packed, 0);
    check("rst_spin_req",   bus.spin_req,    0);
    check("rst_spin_act",   bus.spin_active, 0);
    check("rst_eval_valid", bus.eval_valid,  0);
    check("rst_round_done", bus.round_done,  0);
    check("rst_timeout",    bus.timeout_err, 0);
    check("rst_buf_full",   bus.buf_full,    0);
    reset = 1'b0;
    tick();

    // ---- ignored inputs in BETTING
    bus.wheel_done = 1'b1; bus.wheel_number = 6'd9;
    tick();
    bus.wheel_done = 1'b0;
    check("ign_wheel_state",  bus.state,       0);
    check("ign_wheel_number", bus.eval_number, 0);
    strobe(6'd5, 3'b000);
    strobe(6'h3f, 3'b001);
    strobe(6'h3e, 3'b001);
    check("ign_state",  bus.state,       0);
    check("ign_count",  bus.bet_count,   0);
    check("ign_packed", bus.bets_packed, 0);

    // ---- three bets, spin, handshake with eval_ready toggling
    strobe(6'd5,  3'b001);
    check("b1_count", bus.bet_count, 1);
    strobe(6'd12, 3'b010);
    strobe(6'd20, 3'b011);
    check("b3_count",  bus.bet_count,         3);
    check("b3_packed", bus.bets_packed[23:0], 24'hD48C45);
    strobe(6'h3e, 3'b000);
    check("spin_state", bus.state,       1);
    check("spin_req1",  bus.spin_req,    1);
    check("spin_act1",  bus.spin_active, 1);
    tick();
    check("spin_req2",  bus.spin_req,    0);
    check("spin_act2",  bus.spin_active, 1);
    bus.wheel_done = 1'b1; bus.wheel_number = 6'd17;
    tick();
    bus.wheel_done = 1'b0; bus.wheel_number = 6'd0;
    check("ev_state",  bus.state,       2);
    check("ev_valid",  bus.eval_valid,  1);
    check("ev_number", bus.eval_number, 17);
    check("ev_bet0",   bus.eval_bet,    8'h45);
    check("ev_last0",  bus.eval_last,   0);
    strobe(6'd7, 3'b001);  // ignored outside BETTING
    check("ev_ign_count", bus.bet_count, 3);
    check("ev_hold0",  bus.eval_bet,    8'h45);
    bus.eval_ready = 1'b1; tick();
    check("ev_bet1",   bus.eval_bet,    8'h8C);
    check("ev_last1",  bus.eval_last,   0);
    bus.eval_ready = 1'b0; tick();
    check("ev_hold1",  bus.eval_bet,    8'h8C);
    bus.eval_ready = 1'b1; tick();
    check("ev_bet2",   bus.eval_bet,    8'hD4);
    check("ev_last2",  bus.eval_last,   1);
    bus.eval_ready = 1'b0; tick();
    check("ev_hold2",  bus.eval_bet,    8'hD4);
    check("ev_hold_n", bus.eval_number, 17);
    check("ev_no_done", bus.round_done, 0);
    bus.eval_ready = 1'b1; tick();
    bus.eval_ready = 1'b0;
    check("done_pulse", bus.round_done, 1);
    check("done_state", bus.state,      3);
    check("done_valid", bus.eval_valid, 0);
    tick();
    check("post_done",  bus.round_done, 0);
    check("post_state", bus.state,      0);
    check("post_count", bus.bet_count,  0);
    check("post_packed", bus.bets_packed, 0);

    // ---- fill the buffer with 14 bets; last two dropped
    exp_packed = '0;
    for (int i = 0; i < 14; i++) begin
      col = 3'((i % 7) + 1);
      if (i < 12) exp_packed[8*i +: 8] = {col[1:0], 6'(i)};
      strobe(6'(i), col);
      if (i == 10) check("fill11_full", bus.buf_full, 0);
    end
    check("fill_count",  bus.bet_count,   12);
    check("fill_full",   bus.buf_full,    1);
    check("fill_packed", bus.bets_packed, exp_packed);
    strobe(6'h3e, 3'b000);
    check("fill_spin_req", bus.spin_req, 1);
    bus.wheel_done = 1'b1; bus.wheel_number = 6'd36;  // first SPIN cycle
    tick();
    bus.wheel_done = 1'b0;
    check("fill_eval", bus.state, 2);
    bus.eval_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("fill_bet%0d", i),  bus.eval_bet,  exp_packed[8*i +: 8]);
      check($sformatf("fill_last%0d", i), bus.eval_last, (i == 11));
      tick();
    end
    bus.eval_ready = 1'b0;
    check("fill_done",  bus.round_done, 1);
    check("fill_count0", bus.bet_count, 0);
    tick();
    check("fill_bet_state", bus.state, 0);

    // ---- timeout path
    strobe(6'd1, 3'b001);
    strobe(6'd2, 3'b010);
    strobe(6'd3, 3'b011);
    check("to_packed", bus.bets_packed[23:0], 24'hC38241);
    strobe(6'h3e, 3'b000);
    check("to_spin", bus.state, 1);
    repeat (7) tick();
    check("to_still_spin", bus.state, 1);
    tick();
    check("to_state",   bus.state,       0);
    check("to_err",     bus.timeout_err, 1);
    check("to_count",   bus.bet_count,   3);
    check("to_retain",  bus.bets_packed[23:0], 24'hC38241);
    strobe(6'h3e, 3'b000);
    check("to_respin",  bus.state,       1);
    check("to_err_clr", bus.timeout_err, 0);
    repeat (7) tick();
    bus.wheel_done = 1'b1; bus.wheel_number = 6'd33;  // coincident with timeout
    tick();
    bus.wheel_done = 1'b0;
    check("tie_state",  bus.state,       2);
    check("tie_number", bus.eval_number, 33);
    check("tie_err",    bus.timeout_err, 0);
    check("tie_bet0",   bus.eval_bet,    8'h41);

    // ---- asynchronous reset mid-EVAL at index 2
    bus.eval_ready = 1'b1;
    tick();
    tick();
    bus.eval_ready = 1'b0;
    check("mr_bet2",  bus.eval_bet,  8'hC3);
    check("mr_last2", bus.eval_last, 1);
    #3;
    reset = 1'b1;
    #1;
    check("mr_state",  bus.state,       0);
    check("mr_valid",  bus.eval_valid,  0);
    check("mr_bet",    bus.eval_bet,    0);
    check("mr_count",  bus.bet_count,   0);
    check("mr_packed", bus.bets_packed, 0);
    check("mr_number", bus.eval_number, 0);
    check("mr_done",   bus.round_done,  0);
    tick();
    reset = 1'b0;
    tick();
    check("mr_done2",  bus.round_done, 0);
    check("mr_state2", bus.state,      0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
